// File: rtl/cim_array_sched.sv
// Round-robin scheduler sharing the 16x4x8 CIM array between a host port and a compute port.
// Optional post-reset zero sweep of the array is compiled in with CIM_ARRAY_SCHED_INIT_EN.
module cim_array_sched #(
    parameter int ARR_LAT   = 0,
    parameter int NREQ_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [17:0]          req_addr,
    input  logic [31:0]          req_bank,
    input  logic [31:0]          req_din,
    output logic [1:0]           op_code,
    output logic [8:0]           addr,
    output logic [15:0]          data_bank,
    output logic [15:0]          data_in,
    input  logic [15:0]          arr_result,
    output logic                 rsp_valid,
    output logic [NREQ_BITS-1:0] rsp_id,
    output logic [1:0]           rsp_op,
    output logic [15:0]          rsp_data,
    output logic                 init_done
);

    localparam int DEPTH = ARR_LAT + 1;
    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    logic run_s;
    logic init_done_d, init_done_q;

`ifdef CIM_ARRAY_SCHED_INIT_EN
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    state_t     state_q, state_d;
    logic [5:0] k_q, k_d;

    // Sweep counter and INIT/RUN next-state
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_INIT: begin
                k_d = k_q + 6'd1;
                if (k_q == 6'd63) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            k_q     <= 6'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    assign run_s       = (state_q == ST_RUN);
    assign init_done_d = (state_d == ST_RUN);
`else
    assign run_s       = 1'b1;
    assign init_done_d = 1'b1;
`endif

    // Arbitration
    logic       prio_q, prio_d;
    logic       v0_s, v1_s, xfer_s, gid_s;
    logic [1:0] g_op_s;
    logic [8:0] g_addr_s;
    logic [15:0] g_bank_s, g_din_s;

    always_comb begin
        v0_s   = req_valid[0] & run_s & ~rst;
        v1_s   = req_valid[1] & run_s & ~rst;
        xfer_s = v0_s | v1_s;
        if (v0_s && v1_s) begin
            gid_s = prio_q;
        end else if (v1_s) begin
            gid_s = 1'b1;
        end else begin
            gid_s = 1'b0;
        end
        if (!xfer_s) begin
            req_ready = 2'b00;
        end else if (gid_s) begin
            req_ready = 2'b10;
        end else begin
            req_ready = 2'b01;
        end
        prio_d   = xfer_s ? ~gid_s : prio_q;
        g_op_s   = gid_s ? req_op[3:2]     : req_op[1:0];
        g_addr_s = gid_s ? req_addr[17:9]  : req_addr[8:0];
        g_bank_s = gid_s ? req_bank[31:16] : req_bank[15:0];
        g_din_s  = gid_s ? req_din[31:16]  : req_din[15:0];
    end

    // Array command bus
    logic [1:0]  op_code_q, op_code_d;
    logic [8:0]  addr_q, addr_d;
    logic [15:0] data_bank_q, data_bank_d, data_in_q, data_in_d;

    always_comb begin
        op_code_d   = OP_NOP;
        addr_d      = addr_q;
        data_bank_d = data_bank_q;
        data_in_d   = data_in_q;
`ifdef CIM_ARRAY_SCHED_INIT_EN
        if (!run_s) begin
            op_code_d   = OP_WRITE;
            addr_d      = {k_q, 3'b000};
            data_bank_d = 16'd0;
            data_in_d   = 16'd0;
        end else if (xfer_s) begin
`else
        if (xfer_s) begin
`endif
            op_code_d   = g_op_s;
            addr_d      = g_addr_s;
            data_bank_d = g_bank_s;
            data_in_d   = g_din_s;
        end else begin
            op_code_d   = OP_NOP;
        end
    end

    // Response tracking: stage j holds the op driven j cycles ago
    logic [DEPTH-1:0]                pv_q, pv_d;
    logic [DEPTH-1:0][NREQ_BITS-1:0] pid_q, pid_d;
    logic [DEPTH-1:0][1:0]           pop_q, pop_d;
    logic                            rsp_valid_d, rsp_valid_q;
    logic [NREQ_BITS-1:0]            rsp_id_d, rsp_id_q;
    logic [1:0]                      rsp_op_d, rsp_op_q;
    logic [15:0]                     rsp_data_d, rsp_data_q;

    always_comb begin
        pv_d     = pv_q;
        pid_d    = pid_q;
        pop_d    = pop_q;
        pv_d[0]  = xfer_s & ((g_op_s == OP_READ) | (g_op_s == OP_SEARCH));
        pid_d[0] = NREQ_BITS'(gid_s);
        pop_d[0] = g_op_s;
        for (int j = 1; j < DEPTH; j++) begin
            pv_d[j]  = pv_q[j-1];
            pid_d[j] = pid_q[j-1];
            pop_d[j] = pop_q[j-1];
        end
        rsp_valid_d = pv_q[DEPTH-1];
        if (pv_q[DEPTH-1]) begin
            rsp_id_d   = pid_q[DEPTH-1];
            rsp_op_d   = pop_q[DEPTH-1];
            rsp_data_d = arr_result;
        end else begin
            rsp_id_d   = rsp_id_q;
            rsp_op_d   = rsp_op_q;
            rsp_data_d = rsp_data_q;
        end
    end

    // Datapath and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= 1'b0;
            op_code_q   <= OP_NOP;
            addr_q      <= 9'd0;
            data_bank_q <= 16'd0;
            data_in_q   <= 16'd0;
            pv_q        <= '0;
            pid_q       <= '0;
            pop_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_op_q    <= 2'b00;
            rsp_data_q  <= 16'd0;
            init_done_q <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            op_code_q   <= op_code_d;
            addr_q      <= addr_d;
            data_bank_q <= data_bank_d;
            data_in_q   <= data_in_d;
            pv_q        <= pv_d;
            pid_q       <= pid_d;
            pop_q       <= pop_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_op_q    <= rsp_op_d;
            rsp_data_q  <= rsp_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign op_code   = op_code_q;
    assign addr      = addr_q;
    assign data_bank = data_bank_q;
    assign data_in   = data_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_data  = rsp_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_cim_array_sched.sv
// Randomized bench for cim_array_sched against a cycle-indexed queue model of grants,
// bus contents and timed responses; works with or without CIM_ARRAY_SCHED_INIT_EN.
module tb_cim_array_sched;

    localparam int LAT  = 2;
    localparam int NCYC = 700;
`ifdef CIM_ARRAY_SCHED_INIT_EN
    localparam int RUN_CYC  = 64;
    localparam int DONE_CYC = 64;
`else
    localparam int RUN_CYC  = 0;
    localparam int DONE_CYC = 1;
`endif

    logic        clk, rst;
    logic [1:0]  req_valid, req_ready;
    logic [3:0]  req_op;
    logic [17:0] req_addr;
    logic [31:0] req_bank, req_din;
    logic [1:0]  op_code;
    logic [8:0]  addr;
    logic [15:0] data_bank, data_in, arr_result;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [1:0]  rsp_op;
    logic [15:0] rsp_data;
    logic        init_done;

    cim_array_sched #(.ARR_LAT(LAT), .NREQ_BITS(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_bank(req_bank), .req_din(req_din),
        .op_code(op_code), .addr(addr), .data_bank(data_bank), .data_in(data_in),
        .arr_result(arr_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_op(rsp_op), .rsp_data(rsp_data),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         due;
        logic       id;
        logic [1:0] op;
    } rsp_t;

    rsp_t        rq[$];
    logic [15:0] arr_hist [0:NCYC];

    initial begin
        int          rel;
        bit          just_reset, prev_rst, last_read, run, gid, xfer;
        bit [1:0]    granted;
        int          nrst;
        logic        prio;
        logic [1:0]  e_op, g_op;
        logic [8:0]  e_addr;
        logic [15:0] e_bank, e_din;
        logic [1:0]  e_ready;

        rst = 1'b1; req_valid = 2'b00; req_op = 4'hF; req_addr = 18'd0;
        req_bank = 32'd0; req_din = 32'd0; arr_result = 16'd0;
        rel = 0; just_reset = 1'b1; prev_rst = 1'b1; last_read = 1'b0;
        granted = 2'b00; nrst = 0; prio = 1'b0;
        e_op = 2'b11; e_addr = 9'd0; e_bank = 16'd0; e_din = 16'd0;
        @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Registered outputs produced by the previous edge
            if (RUN_CYC > 0 && rel >= 1 && rel <= RUN_CYC) begin
                check_eq("init_op", op_code, 2'b01);
                check_eq("init_addr", addr, 9'((rel - 1) * 8));
                check_eq("init_bank", data_bank, 16'd0);
                check_eq("init_din", data_in, 16'd0);
            end else begin
                check_eq("op_code", op_code, e_op);
                if (e_op != 2'b11 || just_reset) begin
                    check_eq("addr", addr, e_addr);
                    check_eq("data_bank", data_bank, e_bank);
                    check_eq("data_in", data_in, e_din);
                end
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                check_eq("rsp_valid", rsp_valid, 1'b1);
                check_eq("rsp_id", rsp_id, rq[0].id);
                check_eq("rsp_op", rsp_op, rq[0].op);
                check_eq("rsp_data", rsp_data, arr_hist[cyc-1]);
                void'(rq.pop_front());
            end else begin
                check_eq("rsp_idle", rsp_valid, 1'b0);
            end
            if (just_reset) begin
                check_eq("rst_rsp_id", rsp_id, 1'b0);
                check_eq("rst_rsp_op", rsp_op, 2'b00);
                check_eq("rst_rsp_data", rsp_data, 16'd0);
            end
            check_eq("init_done", init_done, (rel >= DONE_CYC) ? 1'b1 : 1'b0);

            // New inputs for this cycle
            arr_result    = 16'($urandom);
            arr_hist[cyc] = arr_result;
            rst = (last_read && cyc > 150 && nrst < 3) ? 1'b1 : 1'b0;
            if (rst) nrst++;
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || granted[i] || prev_rst) begin
                    req_valid[i]          = ($urandom_range(0, 3) != 0);
                    req_op[2*i +: 2]      = 2'($urandom);
                    req_addr[9*i +: 9]    = 9'($urandom);
                    req_bank[16*i +: 16]  = 16'($urandom);
                    req_din[16*i +: 16]   = 16'($urandom);
                end
            end
            #1;

            // Expected grant from the round-robin rule
            run  = (rel >= RUN_CYC) && !rst;
            xfer = run && (req_valid != 2'b00);
            if (req_valid == 2'b11) gid = prio;
            else gid = req_valid[1];
            e_ready = xfer ? (gid ? 2'b10 : 2'b01) : 2'b00;
            check_eq("req_ready", req_ready, e_ready);

            // Advance model across the coming edge
            granted   = 2'b00;
            last_read = 1'b0;
            prev_rst  = rst;
            if (rst) begin
                rq.delete();
                prio = 1'b0; rel = 0; just_reset = 1'b1;
                e_op = 2'b11; e_addr = 9'd0; e_bank = 16'd0; e_din = 16'd0;
            end else begin
                just_reset = 1'b0;
                rel++;
                if (xfer) begin
                    g_op   = req_op[2*gid +: 2];
                    e_op   = g_op;
                    e_addr = req_addr[9*gid +: 9];
                    e_bank = req_bank[16*gid +: 16];
                    e_din  = req_din[16*gid +: 16];
                    granted[gid] = 1'b1;
                    prio = ~gid;
                    if (g_op == 2'b00 || g_op == 2'b10)
                        rq.push_back('{due: cyc + LAT + 2, id: gid, op: g_op});
                    last_read = (g_op == 2'b00);
                end else begin
                    e_op = 2'b11;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
